// File: rtl/gdp_series_engine_if.sv
// gdp_series_engine_if: start/ack handshake, operands and result bus of the series engine
interface gdp_series_engine_if #(parameter int WIDTH = 8);
  logic start;
  logic ack;
  logic [1:0] mode;
  logic [WIDTH-1:0] n_input;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic overflow;
  modport master(output start, ack, mode, n_input, input busy, done, result, overflow);
  modport slave(input start, ack, mode, n_input, output busy, done, result, overflow);
endinterface

// File: rtl/gdp_series_engine.sv
// gdp_series_engine: width-generic multi-mode series accumulator with start/done/ack handshake
// GDP_SERIES_OVERFLOW_EN enables saturating accumulation with a sticky overflow flag
module gdp_series_engine #(parameter int WIDTH = 8) (
  input logic clock,
  input logic reset,
  gdp_series_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, ADD, DEC, DONE} state_t;
`ifdef GDP_SERIES_OVERFLOW_EN
  localparam int TW = WIDTH + 1;
  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] W_V = WIDTH[WIDTH-1:0];
`else
  localparam int TW = WIDTH;
  localparam int SW = WIDTH;
`endif
  state_t state, nxt;
  logic [WIDTH-1:0] n_reg, acc, nm1, acc_nxt;
  logic [1:0] mode_reg;
  logic [TW-1:0] term;
  logic [SW-1:0] sum;
  assign nm1 = n_reg - WIDTH'(1);
  // a shift past the term width yields 0, which is the correct modulo contribution
  always_comb begin
    term = mode_reg == 2'b00 ? TW'(n_reg) :
           mode_reg == 2'b01 ? TW'({n_reg, 1'b0}) :
           mode_reg == 2'b10 ? TW'(1) << nm1 : TW'(1);
    sum = SW'(acc) + SW'(term);
  end
`ifdef GDP_SERIES_OVERFLOW_EN
  logic ovf_reg, ovf_now;
  assign ovf_now = ovf_reg | (|sum[SW-1:WIDTH]) | term[WIDTH] | (mode_reg == 2'b10 && nm1 >= W_V);
  assign acc_nxt = ovf_now ? '1 : sum[WIDTH-1:0];
  assign bus.overflow = ovf_reg;
  always_ff @(posedge clock)
    if (reset || (state == IDLE && bus.start)) ovf_reg <= 1'b0;
    else if (state == ADD && ovf_now) ovf_reg <= 1'b1;
`else
  assign acc_nxt = sum;
  assign bus.overflow = 1'b0;
`endif
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    nxt = state == IDLE  ? (bus.start ? CHECK : IDLE) :
          state == CHECK ? (n_reg == '0 ? DONE : ADD) :
          state == ADD   ? DEC :
          state == DEC   ? (n_reg == WIDTH'(1) ? DONE : ADD) :
                           (bus.ack ? IDLE : DONE);
  end
  always_ff @(posedge clock)
    if (reset) begin
      n_reg <= '0;
      acc <= '0;
      mode_reg <= '0;
    end else if (state == IDLE && bus.start) begin
      n_reg <= bus.n_input;
      mode_reg <= bus.mode;
      acc <= '0;
    end else if (state == ADD) acc <= acc_nxt;
    else if (state == DEC) n_reg <= nm1;
  assign bus.busy = state == CHECK || state == ADD || state == DEC;
  assign bus.done = state == DONE;
  assign bus.result = state == DONE ? acc : '0;
endmodule

// File: doc/gdp_series_engine.md
Name: gdp_series_engine

Overview:
Parametrised successor to the 8-bit summation datapath/control pair. It is a width-generic, multi-mode series accumulator with its own start/done/ack handshake. The block latches n and a mode, then iterates an add/decrement loop until n reaches 0. It holds the registered result until acknowledged. It sits wherever the team previously instantiated the fixed summation GDP, and drives a registered result instead of a tri-state bus.

Parameters:
WIDTH, 8, datapath width of n, accumulator and result; legal range 4..32.

Ports:
clock  input  1  single system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset, sampled on posedge clock.
start  input  1  request; sampled only in IDLE.
ack  input  1  consumer acknowledge; sampled only in DONE.
mode  input  2  series select; latched with n_input on start acceptance.
n_input  input  WIDTH  series length n, unsigned; latched on start acceptance.
busy  output  1  high in CHECK, ADD and DEC.
done  output  1  high only in DONE.
result  output  WIDTH  final accumulator value while done=1, otherwise 0.
overflow  output  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset (clock edge with reset=1): state=IDLE; n_reg=0; acc=0; mode_reg=00; busy=0; done=0; result=0; overflow=0. Reset overrides every other input, including mid-operation and in DONE.
- FSM states: IDLE, CHECK, ADD, DEC, DONE. State, acc, n_reg and the flags are registers. busy, done and result decode from state.
- IDLE: if start=1, latch n_reg=n_input and mode_reg=mode, clear acc and overflow, go to CHECK. Otherwise stay in IDLE.
- CHECK: if n_reg==0, go to DONE; otherwise go to ADD.
- ADD: acc = acc + term(n_reg, mode_reg), truncated to WIDTH bits. Go to DEC.
- DEC: n_reg = n_reg - 1. If the old n_reg was 1, go to DONE; otherwise go to ADD.
- DONE: hold acc. If ack=1, go to IDLE; otherwise stay in DONE.
- Terms are computed in WIDTH+1 bits:
  - mode 00: term = n (triangular sum, n(n+1)/2).
  - mode 01: term = n<<1 (even sum, n(n+1)).
  - mode 10: term = 1<<(n-1) (2^n - 1).
  - mode 11: term = 1 (count, result = n).
- Latency: start sampled at edge k gives done=1 from edge k+1+2n. Examples: n=0 gives k+1; n=22 gives k+45.
- Handshake and boundary rules:
  - start outside IDLE is ignored.
  - ack outside DONE is ignored.
  - start and ack both high in DONE: return to IDLE; start is not accepted that cycle and needs a later IDLE cycle.
  - Holding start high continuously restarts the block on the cycle after each IDLE entry.
  - n_input and mode changes after acceptance have no effect.
  - n = 2^WIDTH - 1 is legal; the loop runs the full count with no wrap of n_reg.
- result and done change only on clock edges; there is no combinational path from any input to any output.

Optional Feature:
Macro GDP_SERIES_OVERFLOW_EN.
- Defined:
  - In ADD, if the (WIDTH+1)-bit sum or the term exceeds 2^WIDTH - 1, set overflow=1 and load acc with all-ones (saturate).
  - In mode 10 the term overflows when n-1 >= WIDTH.
  - Once set, overflow stays at 1 and acc stays saturated until the next start acceptance or reset.
  - Iteration count and latency are unchanged.
- Undefined:
  - acc wraps modulo 2^WIDTH.
  - The overflow port is tied to 0.

Test Plan:
1. WIDTH=8, mode 00, n=0..22 in sequence, ack one cycle after each done -> results match n(n+1)/2 (n=22 -> 253). done rises at edge k+1+2n.
2. WIDTH=8, mode 00, n=23 -> result 20 and overflow=0 without the macro; result 255 and overflow=1 with GDP_SERIES_OVERFLOW_EN.
3. WIDTH=8, mode 01 n=10 -> 110; mode 10 n=8 -> 255 with overflow=0; mode 10 n=9 with the macro -> 255 with overflow=1; mode 11 n=200 -> 200 at edge k+401.
4. WIDTH=16, mode 00, n=361 -> 65341. Change n_input and mode during busy -> result unaffected.
5. Assert reset for one cycle at edge k+10 of an n=22 run -> next cycle is IDLE with done=0, busy=0, result=0, overflow=0. A fresh start with n=3 -> result 6.
6. Hold DONE with ack=0 for 20 cycles -> result stable, done=1, start ignored. Then start=1 and ack=1 together -> IDLE. Start accepted on the following edge.
